// File: rtl/parking_fee_accumulator.sv
// Parking fee accumulator: latches one client class, accumulates 30-min units from button edges
// and runs the select/confirm/cancel flow. Define IDLE_TIMEOUT_EN for an idle auto-cancel in SELECT.
module parking_fee_accumulator #(
  parameter int NUM_CLIENTS = 2,
  parameter int RATE_W = 3,
  parameter logic [NUM_CLIENTS*RATE_W-1:0] RATE_TABLE = {3'd4, 3'd2},
  parameter int FEE_W = 5,
  parameter int MAX_UNITS = 8,
  parameter int TIMEOUT = 1000,
  localparam int UNIT_W = $clog2(MAX_UNITS + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_CLIENTS-1:0] Client,
  input  logic                   Button30Min,
  input  logic                   Button1Hour,
  input  logic                   Button2Hours,
  input  logic                   Confirm,
  input  logic                   Cancel,
  output logic [UNIT_W-1:0]      Units,
  output logic [FEE_W-1:0]       ValueToPay,
  output logic [FEE_W-1:0]       PaidValue,
  output logic [1:0]             State,
  output logic                   P,
  output logic                   Error
);
  localparam int CIDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int SUM_W   = UNIT_W + 3;
  localparam int PROD_W  = UNIT_W + RATE_W;
  localparam int FEE_MAX = (1 << FEE_W) - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SELECT = 2'b01,
    S_PAID   = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          btn_now, btn_prev_q, rise;
  logic [UNIT_W-1:0]   units_q, units_d;
  logic [FEE_W-1:0]    vtp_q, vtp_d, paid_q, paid_d;
  logic                p_q, p_d, err_q, err_d;
  logic [CIDX_W-1:0]   client_q, client_d, client_idx;
  logic                client_valid, dur_any, timeout;
  logic [2:0]          add;
  logic [SUM_W-1:0]    sum;

  function automatic logic [FEE_W-1:0] fee_calc(input logic [UNIT_W-1:0] u,
                                                input logic [CIDX_W-1:0] idx);
    logic [RATE_W-1:0] rate;
    logic [PROD_W-1:0] prod;
    rate = RATE_TABLE[int'(idx)*RATE_W +: RATE_W];
    prod = {{RATE_W{1'b0}}, u} * {{UNIT_W{1'b0}}, rate};
    if (int'(prod) > FEE_MAX) return FEE_W'(FEE_MAX);
    return FEE_W'(prod);
  endfunction

  // Button weights are 1/2/4 units, so the rising-edge bits form the unit increment directly.
  assign btn_now = {Cancel, Confirm, Button2Hours, Button1Hour, Button30Min};
  assign rise    = btn_now & ~btn_prev_q;
  assign add     = rise[2:0];
  assign dur_any = |add;
  assign sum     = SUM_W'(units_q) + SUM_W'(add);

  always_comb begin
    client_valid = ($countones(Client) == 1);
    client_idx   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (Client[i]) client_idx = CIDX_W'(i);
    end
  end

`ifdef IDLE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    timeout    = (state_q == S_SELECT) && (rise == '0) && (idle_cnt_q == CNT_W'(TIMEOUT));
    idle_cnt_d = '0;
    if ((state_q == S_SELECT) && (rise == '0) && !timeout) idle_cnt_d = idle_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    units_d  = units_q;
    vtp_d    = fee_calc(units_q, client_q);
    paid_d   = paid_q;
    p_d      = 1'b0;
    err_d    = err_q;
    client_d = client_q;
    if (rise[4] || timeout) begin
      state_d = S_IDLE;
      units_d = '0;
      vtp_d   = '0;
      err_d   = timeout;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rise[3]) begin
            err_d = 1'b1;
          end else if (dur_any) begin
            if (!client_valid) begin
              err_d = 1'b1;
            end else begin
              client_d = client_idx;
              state_d  = S_SELECT;
              if (sum > SUM_W'(MAX_UNITS)) begin
                units_d = UNIT_W'(MAX_UNITS);
                err_d   = 1'b1;
              end else begin
                units_d = UNIT_W'(sum);
              end
            end
          end
        end
        S_SELECT: begin
          // Fee is taken from Units, not ValueToPay, which may still lag by one cycle.
          if (rise[3]) begin
            state_d = S_PAID;
            p_d     = 1'b1;
            paid_d  = fee_calc(units_q, client_q);
            units_d = '0;
            vtp_d   = '0;
            err_d   = 1'b0;
          end else if (dur_any) begin
            if (sum > SUM_W'(MAX_UNITS)) begin
              units_d = UNIT_W'(MAX_UNITS);
              err_d   = 1'b1;
            end else begin
              units_d = UNIT_W'(sum);
            end
          end
        end
        S_PAID:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Edge history tracks the inputs through reset so buttons held across it do not fire.
      btn_prev_q <= btn_now;
      state_q    <= S_IDLE;
      units_q    <= '0;
      vtp_q      <= '0;
      paid_q     <= '0;
      p_q        <= 1'b0;
      err_q      <= 1'b0;
      client_q   <= '0;
    end else begin
      btn_prev_q <= btn_now;
      state_q    <= state_d;
      units_q    <= units_d;
      vtp_q      <= vtp_d;
      paid_q     <= paid_d;
      p_q        <= p_d;
      err_q      <= err_d;
      client_q   <= client_d;
    end
  end

  assign Units      = units_q;
  assign ValueToPay = vtp_q;
  assign PaidValue  = paid_q;
  assign State      = state_q;
  assign P          = p_q;
  assign Error      = err_q;
endmodule

// File: tb/tb_parking_fee_accumulator.sv
// Scoreboard bench for parking_fee_accumulator: directed test-plan sequence then randomized
// stimulus, each cycle checked against a behavioural tariff model.
module tb_parking_fee_accumulator;
  localparam int RATE0     = 2;
  localparam int RATE1     = 4;
  localparam int FEE_MAX   = 31;
  localparam int MAX_UNITS = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [1:0] Client = '0;
  logic       Button30Min = 1'b0, Button1Hour = 1'b0, Button2Hours = 1'b0;
  logic       Confirm = 1'b0, Cancel = 1'b0;
  logic [3:0] Units;
  logic [4:0] ValueToPay, PaidValue;
  logic [1:0] State;
  logic       P, Error;

  parking_fee_accumulator #(
    .NUM_CLIENTS(2), .RATE_W(3), .RATE_TABLE({3'd4, 3'd2}),
    .FEE_W(5), .MAX_UNITS(8), .TIMEOUT(1000)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Client(Client),
    .Button30Min(Button30Min), .Button1Hour(Button1Hour), .Button2Hours(Button2Hours),
    .Confirm(Confirm), .Cancel(Cancel),
    .Units(Units), .ValueToPay(ValueToPay), .PaidValue(PaidValue),
    .State(State), .P(P), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int units; int vtp; int paid; int state; int p; int err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  bit stim_active = 0;

  // Reference model state (state: 0 idle, 1 selecting, 2 paid)
  int m_state = 0, m_units = 0, m_client = 0, m_err = 0, m_paid = 0, m_vtp = 0, m_p = 0;
  bit [4:0] m_prev = '0;

  function automatic int fee(input int u, input int c);
    int f;
    f = u * ((c == 1) ? RATE1 : RATE0);
    return (f > FEE_MAX) ? FEE_MAX : f;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cycle, act, expv);
    end
  endtask

  // btn = {cancel, confirm, 2h, 1h, 30min}
  task automatic model_step(input bit rst, input bit [1:0] cl, input bit [4:0] btn);
    bit [4:0] r;
    int add, total, next_vtp;
    if (rst) begin
      m_state = 0; m_units = 0; m_client = 0; m_err = 0; m_paid = 0; m_vtp = 0; m_p = 0;
      m_prev = btn;
      return;
    end
    r = btn & ~m_prev;
    m_prev = btn;
    add = (r[0] ? 1 : 0) + (r[1] ? 2 : 0) + (r[2] ? 4 : 0);
    next_vtp = fee(m_units, m_client);
    m_p = 0;
    if (r[4]) begin
      m_state = 0; m_units = 0; next_vtp = 0; m_err = 0;
    end else if (m_state == 2) begin
      m_state = 0;
    end else if (r[3]) begin
      if (m_state == 1) begin
        m_paid = fee(m_units, m_client);
        m_state = 2; m_p = 1; m_units = 0; next_vtp = 0; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (add > 0) begin
      if (m_state == 0 && !(cl == 2'b01 || cl == 2'b10)) begin
        m_err = 1;
      end else begin
        if (m_state == 0) begin
          m_client = (cl == 2'b10) ? 1 : 0;
          m_state = 1;
        end
        total = m_units + add;
        if (total > MAX_UNITS) begin
          m_units = MAX_UNITS; m_err = 1;
        end else begin
          m_units = total;
        end
      end
    end
    m_vtp = next_vtp;
  endtask

  task automatic cyc(input bit rst, input bit [1:0] cl, input bit [4:0] btn);
    exp_t e;
    @(negedge Clk);
    Reset = rst;
    Client = cl;
    {Cancel, Confirm, Button2Hours, Button1Hour, Button30Min} = btn;
    model_step(rst, cl, btn);
    e.units = m_units; e.vtp = m_vtp; e.paid = m_paid;
    e.state = m_state; e.p = m_p; e.err = m_err;
    exp_q.push_back(e);
    stim_active = 1;
    @(posedge Clk);
    #2;
  endtask

  // Monitor: every clock the DUT presents a fresh output set; compare it with the oldest expectation.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("units", int'(Units), e.units);
      check("value_to_pay", int'(ValueToPay), e.vtp);
      check("paid_value", int'(PaidValue), e.paid);
      check("state", int'(State), e.state);
      check("paid_pulse", int'(P), e.p);
      check("error", int'(Error), e.err);
    end else if (stim_active) begin
      check("scoreboard_underflow", 0, 1);
    end
  end

  initial begin
    bit [4:0] cur;
    bit [1:0] cl;
    bit       rst;

    // Reset with everything held high, then release with inputs still high
    cyc(1, 2'b11, 5'b11111);
    cyc(1, 2'b11, 5'b11111);
    check("reset_state", int'(State), 0);
    check("reset_units", int'(Units), 0);
    cyc(0, 2'b11, 5'b11111);
    cyc(0, 2'b11, 5'b11111);
    check("held_no_error", int'(Error), 0);
    check("held_idle", int'(State), 0);
    cyc(0, 2'b00, 5'b00000);

    // Client 1, all three durations at once, then saturation
    cyc(0, 2'b10, 5'b00111);
    check("sum7_units", int'(Units), 7);
    check("sum7_state", int'(State), 1);
    cyc(0, 2'b10, 5'b00000);
    check("sum7_fee", int'(ValueToPay), 28);
    cyc(0, 2'b10, 5'b00001);
    cyc(0, 2'b10, 5'b00000);
    check("units8", int'(Units), 8);
    check("fee_sat", int'(ValueToPay), 31);
    cyc(0, 2'b10, 5'b00001);
    cyc(0, 2'b10, 5'b00000);
    check("over_units", int'(Units), 8);
    check("over_error", int'(Error), 1);
    cyc(0, 2'b10, 5'b10000);
    check("cancel_err", int'(Error), 0);
    cyc(0, 2'b00, 5'b00000);

    // Client 0, two 2-hour presses then confirm
    cyc(0, 2'b01, 5'b00100);
    cyc(0, 2'b01, 5'b00000);
    cyc(0, 2'b01, 5'b00100);
    cyc(0, 2'b01, 5'b00000);
    check("c0_fee16", int'(ValueToPay), 16);
    cyc(0, 2'b01, 5'b01000);
    check("paid_state", int'(State), 2);
    check("paid_p", int'(P), 1);
    check("paid_val16", int'(PaidValue), 16);
    check("paid_units0", int'(Units), 0);
    cyc(0, 2'b01, 5'b00000);
    check("after_paid_idle", int'(State), 0);
    check("after_paid_p", int'(P), 0);

    // Invalid client, then cancel
    cyc(0, 2'b11, 5'b00010);
    check("bad_client_err", int'(Error), 1);
    check("bad_client_idle", int'(State), 0);
    cyc(0, 2'b11, 5'b00000);
    cyc(0, 2'b00, 5'b10000);
    check("bad_client_clr", int'(Error), 0);
    cyc(0, 2'b00, 5'b00000);

    // Cancel and confirm together in SELECT
    cyc(0, 2'b01, 5'b00001);
    cyc(0, 2'b01, 5'b00000);
    cyc(0, 2'b01, 5'b11000);
    check("cc_idle", int'(State), 0);
    check("cc_no_pulse", int'(P), 0);
    check("cc_paid_kept", int'(PaidValue), 16);
    cyc(0, 2'b00, 5'b00000);

    // Confirm right after a unit update, before ValueToPay caught up
    cyc(0, 2'b10, 5'b00001);
    cyc(0, 2'b10, 5'b00010);
    check("lag_units", int'(Units), 3);
    check("lag_fee_old", int'(ValueToPay), 4);
    cyc(0, 2'b10, 5'b01010);
    check("lag_paid", int'(PaidValue), 12);
    cyc(0, 2'b10, 5'b00000);

    // Confirm in IDLE
    cyc(0, 2'b00, 5'b01000);
    check("idle_confirm_err", int'(Error), 1);
    cyc(0, 2'b00, 5'b00000);
    cyc(0, 2'b00, 5'b10000);
    cyc(0, 2'b00, 5'b00000);

    // Randomized traffic
    cur = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 2) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 5) == 0) cur[3] = ~cur[3];
      if ($urandom_range(0, 11) == 0) cur[4] = ~cur[4];
      cl  = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      cyc(rst, cl, cur);
    end

    stim_active = 0;
    repeat (2) @(posedge Clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
